// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg : shared AHB encodings and slave-mux state type
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLV  = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } mux_state_e;

  // One-hot-ish select to slave index (1..3), 0 when unmapped; lowest index wins.
  function automatic logic [1:0] sel_encode(input logic [2:0] hsel);
    logic [1:0] idx;
    idx = 2'd0;
    if (hsel[0])      idx = 2'd1;
    else if (hsel[1]) idx = 2'd2;
    else if (hsel[2]) idx = 2'd3;
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_timeout_cnt.sv
// ============================================================================
// ahb_timeout_cnt : wait-state counter with expiry compare for the slave mux
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  output logic o_expire
);

  localparam logic [7:0] C_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = 8'd0;
    if (i_stall) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the stalled cycle whose count reaches the limit, so the slave
  // gets exactly TIMEOUT_CYCLES wait states before the forced error.
  assign o_expire = i_stall && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/ahb_slave_mux.sv
// ============================================================================
// ahb_slave_mux : 3-slave AHB response mux with built-in default error slave
// Optional wait-state timeout: define AHB_SLAVE_MUX_TIMEOUT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [1:0]        htrans,
  input  logic              hsel_1,
  input  logic              hsel_2,
  input  logic              hsel_3,
  input  logic              hready_1,
  input  logic              hready_2,
  input  logic              hready_3,
  input  logic              hresp_1,
  input  logic              hresp_2,
  input  logic              hresp_3,
  input  logic [DATA_W-1:0] hrdata_1,
  input  logic [DATA_W-1:0] hrdata_2,
  input  logic [DATA_W-1:0] hrdata_3,
  output logic              hready,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  mux_state_e        state_q, state_d;
  logic [1:0]        dsel_q, dsel_d;
  logic              slv_hready;
  logic              slv_hresp;
  logic [DATA_W-1:0] slv_hrdata;
  logic              timeout;
  logic [1:0]        addr_sel;
  logic              addr_active;

  always_comb begin
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    slv_hrdata = '0;
    case (dsel_q)
      2'd1: begin slv_hready = hready_1; slv_hresp = hresp_1; slv_hrdata = hrdata_1; end
      2'd2: begin slv_hready = hready_2; slv_hresp = hresp_2; slv_hrdata = hrdata_2; end
      2'd3: begin slv_hready = hready_3; slv_hresp = hresp_3; slv_hrdata = hrdata_3; end
      default: ;
    endcase
  end

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  ahb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (hclk),
    .rst_n   (hresetn),
    .i_stall ((state_q == S_SLV) && !slv_hready),
    .o_expire(timeout)
  );
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  assign addr_sel    = sel_encode({hsel_3, hsel_2, hsel_1});
  assign addr_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  always_comb begin
    logic capture;
    state_d = state_q;
    dsel_d  = dsel_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE:  capture = 1'b1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  capture = 1'b1;
      S_SLV: begin
        if (timeout) begin
          state_d = S_ERR1;
          dsel_d  = 2'd0;
        end else begin
          capture = slv_hready;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      dsel_d = 2'd0;
      if (!addr_active) begin
        state_d = S_IDLE;
      end else if (addr_sel != 2'd0) begin
        state_d = S_SLV;
        dsel_d  = addr_sel;
      end else begin
        state_d = S_ERR1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      dsel_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    case (state_q)
      S_SLV: begin
        hready = slv_hready;
        hresp  = slv_hresp;
        hrdata = slv_hrdata;
      end
      S_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      S_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
// ============================================================================
// tb_ahb_slave_mux : directed scoreboard bench for ahb_slave_mux
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ahb_slave_mux;

  localparam logic [31:0] D1 = 32'h1111_0001;
  localparam logic [31:0] D2 = 32'hA5A5_0002;
  localparam logic [31:0] D3 = 32'h3333_0003;
  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [1:0]  T_SEQ  = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  htrans;
  logic        hsel_1, hsel_2, hsel_3;
  logic        hready_1, hready_2, hready_3;
  logic        hresp_1, hresp_2, hresp_3;
  logic [31:0] hrdata_1, hrdata_2, hrdata_3;
  logic        hready, hresp;
  logic [31:0] hrdata;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mux #(
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .htrans(htrans),
    .hsel_1(hsel_1), .hsel_2(hsel_2), .hsel_3(hsel_3),
    .hready_1(hready_1), .hready_2(hready_2), .hready_3(hready_3),
    .hresp_1(hresp_1), .hresp_2(hresp_2), .hresp_3(hresp_3),
    .hrdata_1(hrdata_1), .hrdata_2(hrdata_2), .hrdata_3(hrdata_3),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  // Monitor: one expected response per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (hready !== e.rdy || hresp !== e.resp || hrdata !== e.data) begin
          n_fail++;
          $display("FAIL %s: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                   e.name, hready, hresp, hrdata, e.rdy, e.resp, e.data);
        end
      end
    end
  end

  // Drive one cycle of inputs, queue its expected output, advance to next cycle.
  task automatic cyc(input logic [1:0] tr, input logic [2:0] sel,
                     input logic [2:0] rdy, input logic [2:0] rsp,
                     input logic e_rdy, input logic e_resp,
                     input logic [31:0] e_data, input string name);
    exp_t e;
    htrans = tr;
    {hsel_3, hsel_2, hsel_1}       = sel;
    {hready_3, hready_2, hready_1} = rdy;
    {hresp_3, hresp_2, hresp_1}    = rsp;
    e.rdy = e_rdy; e.resp = e_resp; e.data = e_data; e.name = name;
    exp_q.push_back(e);
    @(posedge hclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn = 1'b0;
    htrans  = T_IDLE;
    {hsel_3, hsel_2, hsel_1} = 3'b000;
    hrdata_1 = D1; hrdata_2 = D2; hrdata_3 = D3;
    @(posedge hclk); #1;

    for (int i = 0; i < 3; i++) begin
      hrdata_1 = $urandom; hrdata_2 = $urandom; hrdata_3 = $urandom;
      cyc(T_NSEQ, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 1'b1, 1'b0, 32'h0, "reset");
    end
    hrdata_1 = D1; hrdata_2 = D2; hrdata_3 = D3;
    hresetn  = 1'b1;
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "idle_after_reset");

    // Read slave 2 with two wait states
    cyc(T_NSEQ, 3'b010, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "s2_addr");
    cyc(T_IDLE, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0, D2,    "s2_wait1");
    cyc(T_IDLE, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0, D2,    "s2_wait2");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, D2,    "s2_data");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "s2_idle");

    // Back-to-back slave 1 then slave 3 (SEQ for the second beat)
    cyc(T_NSEQ, 3'b001, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "b2b_addr1");
    cyc(T_SEQ,  3'b100, 3'b111, 3'b000, 1'b1, 1'b0, D1,    "b2b_data1");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, D3,    "b2b_data3");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "b2b_idle");

    // Unmapped NONSEQ -> default-slave two-cycle error
    cyc(T_NSEQ, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "unmap_addr");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0, "unmap_err1");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0, "unmap_err2");
    cyc(T_IDLE, 3'b010, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "idle_sel_ignored");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "idle_no_sel");

    // Multiple selects: lowest index wins
    cyc(T_NSEQ, 3'b110, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "multi_addr");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, D2,    "multi_data");

    // Slave 3 two-cycle ERROR passes through unchanged
    cyc(T_NSEQ, 3'b100, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "s3err_addr");
    cyc(T_IDLE, 3'b000, 3'b011, 3'b100, 1'b0, 1'b1, D3,    "s3err_1");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b100, 1'b1, 1'b1, D3,    "s3err_2");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "s3err_idle");

    // Transfer presented in S_ERR2 is captured
    cyc(T_NSEQ, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "err2cap_addr");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0, "err2cap_err1");
    cyc(T_NSEQ, 3'b001, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0, "err2cap_err2");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, D1,    "err2cap_data");

    // Slave 1 stuck not-ready
    cyc(T_NSEQ, 3'b001, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "stuck_addr");
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
    for (int i = 0; i < 4; i++)
      cyc(T_IDLE, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0, D1, "tmo_wait");
    cyc(T_IDLE, 3'b000, 3'b110, 3'b000, 1'b0, 1'b1, 32'h0, "tmo_err1");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0, "tmo_err2");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "tmo_idle");
`else
    for (int i = 0; i < 8; i++)
      cyc(T_IDLE, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0, D1, "stuck_wait");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, D1,    "stuck_release");
    cyc(T_IDLE, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "stuck_idle");
`endif

    // Reset mid data phase aborts immediately
    cyc(T_NSEQ, 3'b010, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0, "rstmid_addr");
    cyc(T_IDLE, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0, D2,    "rstmid_wait");
    hresetn = 1'b0;
    cyc(T_NSEQ, 3'b010, 3'b101, 3'b010, 1'b1, 1'b0, 32'h0, "rstmid_reset");
    hresetn = 1'b1;
    cyc(T_IDLE, 3'b000, 3'b101, 3'b010, 1'b1, 1'b0, 32'h0, "rstmid_after");

    @(negedge hclk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Slave-to-master response multiplexer for the 3-slave AHB system; sits directly downstream of the address decoder and consumes its one-hot `hsel_1..3`. It registers the address-phase slave select into a data-phase select. It forwards the selected slave's `hready`/`hresp`/`hrdata` to the master. Transfers to an unmapped address (no `hsel` asserted) receive a built-in default-slave two-cycle ERROR response.

## Interface
Parameters:
- `DATA_W`, 32, read data width
- `TIMEOUT_CYCLES`, 16, wait-state limit before forced ERROR (used only with timeout feature; legal range 2..255)

Ports:
- `hclk`  in  1  system clock; single clock domain, all state on rising edge
- `hresetn`  in  1  asynchronous active-low reset
- `htrans`  in  2  master transfer type (address phase)
- `hsel_1`, `hsel_2`, `hsel_3`  in  1 each  decoder slave selects (address phase)
- `hready_1..3`  in  1 each  slave ready outputs
- `hresp_1..3`  in  1 each  slave response (0 OKAY, 1 ERROR)
- `hrdata_1..3`  in  DATA_W each  slave read data
- `hready`  out  1  ready to master and fed back to all slaves
- `hresp`  out  1  response to master
- `hrdata`  out  DATA_W  read data to master

## Operation
- States: `S_IDLE` (no data phase pending), `S_SLV` (forwarding slave `dsel`), `S_ERR1`, `S_ERR2` (default-slave error).
- Address capture happens on any rising edge where `hready`=1:
  - `htrans[1]`=1 with some `hsel_n`=1 → `S_SLV`, `dsel`=n.
  - `htrans[1]`=1 with no `hsel` → `S_ERR1`.
  - `htrans` IDLE/BUSY → `S_IDLE`. `hsel` is ignored.
- Multiple `hsel` high (illegal): lowest index wins; no error raised.
- Outputs by state:
  - `S_IDLE`: `hready`=1, `hresp`=0, `hrdata`=0.
  - `S_SLV`: outputs equal `hready_dsel`, `hresp_dsel`, `hrdata_dsel` (combinational path).
  - `S_ERR1`: `hready`=0, `hresp`=1, `hrdata`=0.
  - `S_ERR2`: `hready`=1, `hresp`=1, `hrdata`=0.
- Transitions:
  - `S_ERR1` → `S_ERR2` unconditionally.
  - `S_ERR2` and `S_SLV` with `hready_dsel`=1 perform address capture.
  - `S_SLV` with `hready_dsel`=0 holds.
- A slave two-cycle ERROR is forwarded unchanged; the mux adds no cycles.

## Timing
- Reset (async assert, sync deassert by the system): state `S_IDLE`, `dsel`=0. Outputs are therefore `hready`=1, `hresp`=0, `hrdata`=0.
- Reset mid-transfer aborts any data phase immediately; outputs return to reset values the same cycle.
- Zero added latency on the slave response path: slave outputs reach the master combinationally during `S_SLV`.
- Select latency is one cycle: `dsel` updates on the edge ending the address phase.
- Back-to-back transfers to different slaves switch `dsel` on the edge where the previous data phase completes.
- Unmapped NONSEQ/SEQ gets its response 2 cycles after address phase (`hready` low 1 cycle).
- A transfer presented during `S_ERR2` is captured normally. Masters are expected to drive IDLE there, but the mux does not enforce it.

## Configuration
- Macro: `AHB_SLAVE_MUX_TIMEOUT_EN`.
- With the macro defined:
  - In `S_SLV`, an 8-bit counter increments each cycle `hready_dsel`=0 and clears on any state change or `hready_dsel`=1.
  - When the counter reaches `TIMEOUT_CYCLES`, the next state is `S_ERR1`, and slave outputs are masked from then on.
  - The slave's late `hready` is ignored.
- Without the macro: no counter; the mux waits indefinitely on the slave.

## Structure
- Shared package `ahb_pkg`:
  - `HTRANS_IDLE`/`BUSY`/`NONSEQ`/`SEQ` (00/01/10/11).
  - `HRESP_OKAY`/`ERROR` (0/1).
  - Mux state encoding, 2 bits.
- One sub-module: `ahb_timeout_cnt`, containing the counter plus compare. It is instantiated only under `AHB_SLAVE_MUX_TIMEOUT_EN`.

## Test plan
- Reset: hold `hresetn`=0 with random slave inputs → `hready`=1, `hresp`=0, `hrdata`=0.
- Read slave 2: NONSEQ with `hsel_2`, `hrdata_2`=0xA5A5_0002, 2 wait states → `hready` low 2 cycles, then `hrdata`=0xA5A5_0002 with `hresp`=0. Slaves 1/3 data never visible.
- Back-to-back: slave 1 then slave 3, zero wait → `hrdata` shows `hrdata_1` then `hrdata_3` on consecutive cycles.
- Unmapped: NONSEQ with no `hsel` → (`hready`,`hresp`) = (0,1) then (1,1); IDLE with no `hsel` → (1,0).
- Slave ERROR passthrough: `hresp_3`=1 for two cycles with `hready_3` 0→1 → identical sequence on `hresp`/`hready`.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): `hready_1` stuck 0 → `hready` low 4 cycles, then (0,1), (1,1). Without the macro, `hready` stays low.
